// File: rtl/sha3_pkg.sv
// Shared constants and types for the SHA-3 rate-block padder.
// Rate tables are indexed by the SHA-3 variant selected on the mode input.
package sha3_pkg;

  localparam int WIDTH          = 16;
  localparam int RATE_MAX_BITS  = 1152;
  localparam int RATE_MAX_BYTES = RATE_MAX_BITS / 8;

  typedef enum logic [1:0] {
    MODE_224 = 2'd0,
    MODE_256 = 2'd1,
    MODE_384 = 2'd2,
    MODE_512 = 2'd3
  } sha3_mode_e;

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_PADBLK = 2'd2
  } pad_state_e;

  localparam logic [6:0] RATE_WORDS [4] = '{7'd72, 7'd68, 7'd52, 7'd36};
  localparam logic [7:0] RATE_BYTES [4] = '{8'd144, 8'd136, 8'd104, 8'd72};

  function automatic logic [6:0] rate_words(input sha3_mode_e m);
    return RATE_WORDS[m];
  endfunction

  function automatic logic [7:0] rate_bytes(input sha3_mode_e m);
    return RATE_BYTES[m];
  endfunction

endpackage

// File: rtl/sha3_pad_gen.sv
// Combinational pad10*1 mask: 0x06 domain byte at position pos, 0x80 on the
// final rate byte; both land on the same byte when pos is the last rate byte.
module sha3_pad_gen
  import sha3_pkg::*;
(
  input  sha3_mode_e               mode,
  input  logic [7:0]               pos,
  output logic [RATE_MAX_BITS-1:0] mask
);

  logic [7:0] last_byte;

  assign last_byte = rate_bytes(mode) - 8'd1;

  for (genvar gi = 0; gi < RATE_MAX_BYTES; gi++) begin : g_byte
    assign mask[8*gi +: 8] = ((pos == 8'(gi))       ? 8'h06 : 8'h00) |
                             ((last_byte == 8'(gi)) ? 8'h80 : 8'h00);
  end

endmodule

// File: rtl/sha3_padder.sv
// Packs a 16-bit AXI-Stream byte message into SHA-3 rate blocks, applies the
// 0x06 / 0x80 padding and hands each block to the Keccak core.
module sha3_padder
  import sha3_pkg::*;
(
  input  logic                     ACLK,
  input  logic                     ARESETn,
  input  logic [WIDTH-1:0]         s_tdata,
  input  logic [1:0]               s_tkeep,
  input  logic                     s_tvalid,
  input  logic                     s_tlast,
  output logic                     s_tready,
  input  logic [1:0]               mode,
  output logic [RATE_MAX_BITS-1:0] blk_data,
  output logic                     blk_valid,
  input  logic                     blk_ready,
  output logic                     blk_first,
  output logic                     blk_last,
  output logic [1:0]               blk_mode
);

  pad_state_e               state_reg, state_next;
  logic [6:0]               cnt_reg, cnt_next;
  logic                     pad_pending_reg, pad_pending_next;
  logic [RATE_MAX_BITS-1:0] block_reg, block_next;
  logic                     first_reg, first_next;
  logic                     last_reg, last_next;
  sha3_mode_e               mode_reg, mode_next;

  logic                     accept;
  logic                     msg_start;
  sha3_mode_e               beat_mode;
  logic [1:0]               beat_bytes;
  logic [WIDTH-1:0]         beat_word;
  logic [7:0]               fill_bytes;
  sha3_mode_e               pad_mode;
  logic [7:0]               pad_pos;
  logic [RATE_MAX_BITS-1:0] pad_mask;

  assign s_tready = (state_reg == ST_FILL) && ARESETn;
  assign accept   = s_tvalid && s_tready;

  // A new message starts on the first beat after a final block (or reset);
  // only then is the external mode sampled.
  assign msg_start = first_reg && (cnt_reg == 7'd0);
  assign beat_mode = msg_start ? sha3_mode_e'(mode) : mode_reg;

  // Partial keep only has meaning on the closing beat.
  always_comb begin
    beat_bytes = 2'd2;
    if (s_tlast) begin
      case (s_tkeep)
        2'b00:   beat_bytes = 2'd0;
        2'b01:   beat_bytes = 2'd1;
        default: beat_bytes = 2'd2;
      endcase
    end
  end

  assign beat_word  = {(beat_bytes == 2'd2) ? s_tdata[15:8] : 8'h00,
                       (beat_bytes != 2'd0) ? s_tdata[7:0]  : 8'h00};
  assign fill_bytes = {cnt_reg, 1'b0} + {6'd0, beat_bytes};

  assign pad_mode = (state_reg == ST_PADBLK) ? mode_reg : beat_mode;
  assign pad_pos  = (state_reg == ST_PADBLK) ? 8'd0 : fill_bytes;

  sha3_pad_gen u_pad_gen (
    .mode (pad_mode),
    .pos  (pad_pos),
    .mask (pad_mask)
  );

  always_comb begin
    state_next       = state_reg;
    cnt_next         = cnt_reg;
    pad_pending_next = pad_pending_reg;
    block_next       = block_reg;
    first_next       = first_reg;
    last_next        = last_reg;
    mode_next        = mode_reg;
    case (state_reg)
      ST_FILL: begin
        if (accept) begin
          mode_next = beat_mode;
          block_next[WIDTH*cnt_reg +: WIDTH] = beat_word;
          cnt_next = cnt_reg + 7'd1;
          if (s_tlast) begin
            state_next = ST_HOLD;
            if (fill_bytes < rate_bytes(beat_mode)) begin
              block_next = block_next | pad_mask;
              last_next  = 1'b1;
            end else begin
              // Message exactly filled the rate: padding goes in its own block.
              pad_pending_next = 1'b1;
              last_next        = 1'b0;
            end
          end else if (cnt_reg == rate_words(beat_mode) - 7'd1) begin
            state_next = ST_HOLD;
            last_next  = 1'b0;
          end
        end
      end
      ST_HOLD: begin
        if (blk_ready) begin
          block_next = '0;
          cnt_next   = 7'd0;
          first_next = last_reg;
          last_next  = 1'b0;
          state_next = pad_pending_reg ? ST_PADBLK : ST_FILL;
        end
      end
      ST_PADBLK: begin
        block_next       = block_reg | pad_mask;
        pad_pending_next = 1'b0;
        last_next        = 1'b1;
        state_next       = ST_HOLD;
      end
      default: state_next = ST_FILL;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_reg       <= ST_FILL;
      cnt_reg         <= 7'd0;
      pad_pending_reg <= 1'b0;
      block_reg       <= '0;
      first_reg       <= 1'b1;
      last_reg        <= 1'b0;
      mode_reg        <= MODE_224;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      pad_pending_reg <= pad_pending_next;
      block_reg       <= block_next;
      first_reg       <= first_next;
      last_reg        <= last_next;
      mode_reg        <= mode_next;
    end
  end

  assign blk_data  = block_reg;
  assign blk_valid = (state_reg == ST_HOLD);
  assign blk_first = first_reg;
  assign blk_last  = last_reg;
  assign blk_mode  = mode_reg;

endmodule

// File: tb/tb_sha3_padder.sv
// Bench for sha3_padder: directed vector table, stall/reset sequences and
// random messages checked against a byte-level SHA-3 padding model.
`timescale 1ns/1ps
module tb_sha3_padder;

  logic          ACLK = 1'b0;
  logic          ARESETn = 1'b0;
  logic [15:0]   s_tdata = '0;
  logic [1:0]    s_tkeep = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tlast = 1'b0;
  logic          s_tready;
  logic [1:0]    mode = '0;
  logic [1151:0] blk_data;
  logic          blk_valid;
  logic          blk_ready = 1'b0;
  logic          blk_first;
  logic          blk_last;
  logic [1:0]    blk_mode;

  always #5 ACLK = ~ACLK;

  sha3_padder dut (
    .ACLK      (ACLK),
    .ARESETn   (ARESETn),
    .s_tdata   (s_tdata),
    .s_tkeep   (s_tkeep),
    .s_tvalid  (s_tvalid),
    .s_tlast   (s_tlast),
    .s_tready  (s_tready),
    .mode      (mode),
    .blk_data  (blk_data),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_first (blk_first),
    .blk_last  (blk_last),
    .blk_mode  (blk_mode)
  );

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [1151:0] data;
    logic          first;
    logic          last;
    logic [1:0]    mode;
  } blk_t;
  typedef struct {
    int         mode;
    int         len;
    int         exp_blocks;
    int         chk_byte;
    logic [7:0] chk_val;
  } vec_t;

  int            total = 0;
  int            bad = 0;
  blk_t          exp_q[$];
  int            ready_ctl = 0;   // 0 random, 1 held low, 2 held high
  int            hs_count = 0;
  logic [1151:0] last_seen = '0;
  bit            scramble = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic check_blk(input string name, input logic [1151:0] act, input logic [1151:0] exp);
    int idx;
    idx = 0;
    total++;
    if (act !== exp) begin
      bad++;
      for (int i = 143; i >= 0; i--)
        if (act[8*i +: 8] !== exp[8*i +: 8]) idx = i;
      $display("FAIL %s byte %0d: got %02h want %02h", name, idx, act[8*idx +: 8], exp[8*idx +: 8]);
    end
  endtask

  function automatic int rate_of(input int m);
    case (m)
      0:       return 144;
      1:       return 136;
      2:       return 104;
      default: return 72;
    endcase
  endfunction

  // Reference: append 0x06, zero-fill to a whole number of rate blocks, OR 0x80 into the final byte.
  task automatic expect_msg(input int m, input bq_t msg);
    int   rb;
    int   plen;
    bq_t  padded;
    blk_t e;
    rb   = rate_of(m);
    plen = (msg.size() / rb + 1) * rb;
    padded = msg;
    padded.push_back(8'h06);
    while (padded.size() < plen) padded.push_back(8'h00);
    padded[plen-1] = padded[plen-1] | 8'h80;
    for (int b = 0; b < plen / rb; b++) begin
      e.data = '0;
      for (int i = 0; i < rb; i++) e.data[8*i +: 8] = padded[b*rb + i];
      e.first = (b == 0);
      e.last  = (b == plen / rb - 1);
      e.mode  = 2'(m);
      exp_q.push_back(e);
    end
  endtask

  // Block sink: compares every handshaken block against the model queue.
  initial begin
    blk_t e;
    forever begin
      @(negedge ACLK);
      case (ready_ctl)
        1:       blk_ready = 1'b0;
        2:       blk_ready = 1'b1;
        default: blk_ready = ($urandom_range(0, 2) != 0);
      endcase
      if (ARESETn && blk_valid && blk_ready) begin
        hs_count++;
        last_seen = blk_data;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_block: got block mode=%0d last=%0b, want none", blk_mode, blk_last);
        end else begin
          e = exp_q.pop_front();
          $display("block %0d: mode=%0d first=%0b last=%0b", hs_count, blk_mode, blk_first, blk_last);
          check_blk("blk_data", blk_data, e.data);
          check("blk_first", 64'(blk_first), 64'(e.first));
          check("blk_last", 64'(blk_last), 64'(e.last));
          check("blk_mode", 64'(blk_mode), 64'(e.mode));
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the beat was accepted.
  task automatic send_beat(input logic [15:0] d, input logic [1:0] k, input logic l);
    int guard;
    guard = 0;
    s_tdata  = d;
    s_tkeep  = k;
    s_tlast  = l;
    s_tvalid = 1'b1;
    while (!s_tready && guard < 3000) begin
      @(negedge ACLK);
      guard++;
    end
    if (!s_tready) begin
      total++;
      bad++;
      $display("FAIL beat_timeout: got s_tready=0 after %0d cycles, want 1", guard);
      s_tvalid = 1'b0;
      return;
    end
    @(negedge ACLK);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    if (scramble) mode = 2'($urandom);
    if (l) check("latency_valid", 64'(blk_valid), 64'd1);
    if (scramble && $urandom_range(0, 3) == 0) @(negedge ACLK);
  endtask

  task automatic send_msg(input int m, input bq_t msg, input bit extra, input bit junk);
    int         n;
    bit         lst;
    logic [1:0] k;
    n = msg.size();
    mode = 2'(m);
    if (n == 0) begin
      send_beat(16'($urandom), 2'b00, 1'b1);
    end else begin
      for (int i = 0; i < n / 2; i++) begin
        lst = (i == n / 2 - 1) && (n % 2 == 0) && !extra;
        k   = (!lst && junk) ? 2'($urandom) : 2'b11;
        send_beat({msg[2*i+1], msg[2*i]}, k, lst);
      end
      if (n % 2 == 1) send_beat({8'($urandom), msg[n-1]}, 2'b01, 1'b1);
      else if (extra) send_beat(16'($urandom), 2'b00, 1'b1);
    end
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 3000) begin
      @(negedge ACLK);
      guard++;
    end
    check("drain_pending", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish by %0t, want finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t          vecs[8];
    bq_t           msg;
    int            hs0;
    logic [1151:0] snap;

    vecs[0] = '{1,   0, 1,   0, 8'h06};
    vecs[1] = '{0,   2, 1,   2, 8'h06};
    vecs[2] = '{3,  71, 1,  71, 8'h86};
    vecs[3] = '{3,  72, 2,   0, 8'h06};
    vecs[4] = '{2, 103, 1, 103, 8'h86};
    vecs[5] = '{0, 144, 2, 143, 8'h80};
    vecs[6] = '{2, 200, 2,  96, 8'h06};
    vecs[7] = '{1, 135, 1, 135, 8'h86};

    // Reset values
    repeat (3) @(negedge ACLK);
    check("rst_tready", 64'(s_tready), 64'd0);
    check("rst_valid", 64'(blk_valid), 64'd0);
    check("rst_first", 64'(blk_first), 64'd1);
    check("rst_last", 64'(blk_last), 64'd0);
    check("rst_mode", 64'(blk_mode), 64'd0);
    check_blk("rst_data", blk_data, '0);
    ARESETn = 1'b1;
    @(negedge ACLK);

    // Directed vectors: message byte i is 'a'+i
    for (int v = 0; v < 8; v++) begin
      msg.delete();
      for (int i = 0; i < vecs[v].len; i++) msg.push_back(8'(i + 'h61));
      hs0 = hs_count;
      $display("vector %0d: mode=%0d len=%0d", v, vecs[v].mode, vecs[v].len);
      expect_msg(vecs[v].mode, msg);
      send_msg(vecs[v].mode, msg, 1'b0, 1'b0);
      wait_drain();
      check("vec_blocks", 64'(hs_count - hs0), 64'(vecs[v].exp_blocks));
      check("vec_spot", 64'(last_seen[8*vecs[v].chk_byte +: 8]), 64'(vecs[v].chk_val));
    end

    // Back-pressure: full mode-1 block held for 10 cycles, then a lone empty tlast beat
    msg.delete();
    for (int i = 0; i < 136; i++) msg.push_back(8'(i + 'h61));
    expect_msg(1, msg);
    ready_ctl = 1;
    mode = 2'd1;
    for (int i = 0; i < 68; i++) send_beat({msg[2*i+1], msg[2*i]}, 2'b11, 1'b0);
    check("stall_valid", 64'(blk_valid), 64'd1);
    snap = blk_data;
    hs0 = hs_count;
    for (int c = 0; c < 10; c++) begin
      @(negedge ACLK);
      check("stall_tready", 64'(s_tready), 64'd0);
      check("stall_stable", 64'(blk_data === snap), 64'd1);
    end
    ready_ctl = 2;
    repeat (4) @(negedge ACLK);
    check("stall_handshakes", 64'(hs_count - hs0), 64'd1);
    check("stall_valid_after", 64'(blk_valid), 64'd0);
    ready_ctl = 0;
    send_beat(16'hbeef, 2'b00, 1'b1);
    wait_drain();
    check("padblk_first", 64'(last_seen[7:0]), 64'h06);

    // Reset mid-message and mid-HOLD discards the partial block
    hs0 = hs_count;
    mode = 2'd0;
    for (int i = 0; i < 20; i++) send_beat(16'($urandom), 2'b11, 1'b0);
    ARESETn = 1'b0;
    repeat (3) begin
      @(negedge ACLK);
      check("rst_mid_tready", 64'(s_tready), 64'd0);
      check("rst_mid_valid", 64'(blk_valid), 64'd0);
    end
    ARESETn = 1'b1;
    @(negedge ACLK);
    msg.delete();
    msg.push_back(8'h61);
    msg.push_back(8'h62);
    expect_msg(0, msg);
    send_msg(0, msg, 1'b0, 1'b0);
    wait_drain();
    check("rst_ab_blocks", 64'(hs_count - hs0), 64'd1);
    check("rst_ab_pad", 64'(last_seen[23:0]), 64'h066261);

    ready_ctl = 1;
    mode = 2'd3;
    for (int i = 0; i < 36; i++) send_beat(16'($urandom), 2'b11, 1'b0);
    check("hold_before_rst", 64'(blk_valid), 64'd1);
    ARESETn = 1'b0;
    @(negedge ACLK);
    check("hold_rst_valid", 64'(blk_valid), 64'd0);
    ARESETn = 1'b1;
    ready_ctl = 0;
    @(negedge ACLK);
    expect_msg(0, msg);
    send_msg(0, msg, 1'b0, 1'b0);
    wait_drain();
    check("hold_rst_blocks", 64'(hs_count - hs0), 64'd2);

    // Random messages; mode input is scrambled after the first beat
    scramble = 1'b1;
    for (int t = 0; t < 40; t++) begin
      int m;
      int n;
      bit extra;
      m = $urandom_range(0, 3);
      n = $urandom_range(0, 300);
      msg.delete();
      for (int i = 0; i < n; i++) msg.push_back(8'($urandom));
      extra = (n > 0) && (n % 2 == 0) && ($urandom_range(0, 3) == 0);
      $display("random %0d: mode=%0d len=%0d extra=%0b", t, m, n, extra);
      expect_msg(m, msg);
      send_msg(m, msg, extra, 1'($urandom));
    end
    scramble = 1'b0;
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
